// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM among loader, CPU data and CPU fetch ports
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   ld_req/we/addr/wdata/gnt     program loader port (highest priority, bounded by LD_MAX)
//   dat_req/we/addr/wdata/gnt    CPU data port (round-robin with fetch)
//   if_req/addr/gnt              CPU instruction fetch port (read only)
//   rdata, *_rvalid              read return, one cycle after a read grant, tagged by owner
//   mem_en/we/addr/wdata/rdata   RAM macro interface, 1-cycle read latency
module mem_port_arbiter #(
    parameter int AW     = 9,
    parameter int DW     = 16,
    parameter int LD_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    input  logic          dat_req,
    input  logic          dat_we,
    input  logic [AW-1:0] dat_addr,
    input  logic [DW-1:0] dat_wdata,
    output logic          dat_gnt,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic [DW-1:0] rdata,
    output logic          ld_rvalid,
    output logic          dat_rvalid,
    output logic          if_rvalid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    // LD_MAX=0 still needs a 1-bit counter that simply stays at zero
    localparam int CW = (LD_MAX > 0) ? $clog2(LD_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(LD_MAX);

    typedef enum logic {RR_DAT, RR_IF} rr_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_LD, OWN_DAT, OWN_IF} own_t;

    rr_t           rr_last;
    own_t          owner;
    logic          rd_pend;
    logic [CW-1:0] ld_cnt;
    logic          cpu_req;
    logic          ld_block;

    // Grants are forced low during reset so no write slips through on the reset edge
    always_comb begin
        cpu_req   = dat_req | if_req;
        ld_block  = (ld_cnt == CNT_MAX) && cpu_req;
        ld_gnt    = ~rst & ld_req & ~ld_block;
        dat_gnt   = ~rst & ~ld_gnt & dat_req & (~if_req | (rr_last == RR_IF));
        if_gnt    = ~rst & ~ld_gnt & if_req & (~dat_req | (rr_last == RR_DAT));
        mem_en    = ld_gnt | dat_gnt | if_gnt;
        mem_we    = ld_gnt ? ld_we : (dat_gnt & dat_we);
        mem_addr  = ld_gnt ? ld_addr : dat_gnt ? dat_addr : if_addr;
        mem_wdata = ld_gnt ? ld_wdata : dat_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last <= RR_IF;
            ld_cnt  <= '0;
            owner   <= OWN_NONE;
            rd_pend <= 1'b0;
        end else begin
            if (dat_gnt)
                rr_last <= RR_DAT;
            else if (if_gnt)
                rr_last <= RR_IF;
            // counts loader wins over a waiting CPU; any CPU progress or idle CPU resets it
            if (dat_gnt | if_gnt | ~cpu_req)
                ld_cnt <= '0;
            else if (ld_gnt && ld_cnt != CNT_MAX)
                ld_cnt <= ld_cnt + 1'b1;
            rd_pend <= mem_en & ~mem_we;
            owner   <= ld_gnt ? OWN_LD : dat_gnt ? OWN_DAT : if_gnt ? OWN_IF : OWN_NONE;
        end
    end

    assign rdata      = mem_rdata;
    assign ld_rvalid  = rd_pend && (owner == OWN_LD);
    assign dat_rvalid = rd_pend && (owner == OWN_DAT);
    assign if_rvalid  = rd_pend && (owner == OWN_IF);
endmodule
